// File: rtl/common.sv
// Shared IF/ID types: the decoded-entry payload, skid FSM states and the NOP filler.
package common;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [31:0] instruction_type;

    typedef struct packed {
        instruction_type   instr;
        logic [XLEN-1:0]   pc;
        logic              compressed;
        logic              illegal;
    } if_id_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_t;

    // Entries lost to a flush: main unless it leaves this cycle, plus skid if occupied.
    function automatic logic [1:0] flush_drop_count(skid_state_t st, logic id_ready);
        logic [1:0] n;
        n = 2'd0;
        if (st != EMPTY && !id_ready) begin
            n = n + 2'd1;
        end
        if (st == SKID) begin
            n = n + 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/if_id_perf_ctr.sv
// Saturating 32-bit stall / flush-drop counters for the IF/ID skid register.
module if_id_perf_ctr
    import common::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_inc,
    input  logic [1:0]  flush_drop,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    logic [1:0]       inc   [2];
    logic [1:0][31:0] cnt_bus;

    assign inc[0] = {1'b0, stall_inc};
    assign inc[1] = flush_drop;

    function automatic logic [31:0] sat_add(logic [31:0] a, logic [1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'd0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ctr
            logic [31:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_reg <= 32'd0;
                end else if (inc[gi] != 2'd0) begin
                    cnt_reg <= sat_add(cnt_reg, inc[gi]);
                end
            end
            assign cnt_bus[gi] = cnt_reg;
        end
    endgenerate

    assign perf_stall_cnt = cnt_bus[0];
    assign perf_flush_cnt = cnt_bus[1];

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID boundary with a 2-entry skid buffer so if_ready depends only on registered state.
// Optional performance counters are enabled by defining IF_ID_PERF_EN.
module if_id_skid_reg
    import common::*;
#(
    parameter int          XLEN      = common::XLEN,
    parameter logic [31:0] NOP_INSTR = common::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            if_compressed,
    input  logic            if_illegal,
    input  logic            if_id_flush,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_link_pc,
    output logic            id_compressed,
    output logic            id_illegal
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam if_id_entry_t RESET_ENTRY = '{instr: NOP_INSTR, pc: '0,
                                             compressed: 1'b0, illegal: 1'b0};

    skid_state_t  state_reg;
    if_id_entry_t main_reg;
    if_id_entry_t skid_reg;
    if_id_entry_t in_entry;
    logic         if_ready_reg;
    logic         id_valid_reg;

    assign in_entry = '{instr: if_instr, pc: if_pc,
                        compressed: if_compressed, illegal: if_illegal};

    // Payload registers only move on an accepted transfer; a flush just retires state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= EMPTY;
            main_reg     <= RESET_ENTRY;
            skid_reg     <= RESET_ENTRY;
            if_ready_reg <= 1'b1;
            id_valid_reg <= 1'b0;
        end else if (if_id_flush) begin
            state_reg    <= EMPTY;
            if_ready_reg <= 1'b1;
            id_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (if_valid) begin
                        main_reg     <= in_entry;
                        state_reg    <= FULL;
                        id_valid_reg <= 1'b1;
                    end
                end
                FULL: begin
                    if (if_valid && id_ready) begin
                        main_reg <= in_entry;
                    end else if (if_valid) begin
                        skid_reg     <= in_entry;
                        state_reg    <= SKID;
                        if_ready_reg <= 1'b0;
                    end else if (id_ready) begin
                        state_reg    <= EMPTY;
                        id_valid_reg <= 1'b0;
                    end
                end
                SKID: begin
                    if (id_ready) begin
                        main_reg     <= skid_reg;
                        state_reg    <= FULL;
                        if_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= EMPTY;
                    if_ready_reg <= 1'b1;
                    id_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign if_ready      = if_ready_reg;
    assign id_valid      = id_valid_reg;
    assign id_instr      = id_valid_reg ? main_reg.instr : NOP_INSTR;
    assign id_pc         = main_reg.pc;
    assign id_compressed = main_reg.compressed;
    assign id_illegal    = id_valid_reg & main_reg.illegal;
    assign id_link_pc    = main_reg.pc + (main_reg.compressed ? XLEN'(2) : XLEN'(4));

`ifdef IF_ID_PERF_EN
    logic [1:0] flush_drop;
    logic       stall_inc;

    assign flush_drop = if_id_flush ? flush_drop_count(state_reg, id_ready) : 2'd0;
    assign stall_inc  = id_valid_reg & ~id_ready;

    if_id_perf_ctr u_perf (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall_inc      (stall_inc),
        .flush_drop     (flush_drop),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: directed vectors push expected entries, a negedge
// monitor compares the presented output against the head of the expected queue.
module tb_if_id_skid_reg;
    import common::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_compressed;
    logic        if_illegal;
    logic        if_id_flush;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_link_pc;
    logic        id_compressed;
    logic        id_illegal;
`ifdef IF_ID_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    if_id_skid_reg dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_compressed (if_compressed),
        .if_illegal    (if_illegal),
        .if_id_flush   (if_id_flush),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_link_pc    (id_link_pc),
        .id_compressed (id_compressed),
        .id_illegal    (id_illegal)
`ifdef IF_ID_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] link;
        logic        comp;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          started  = 1'b0;
    logic [31:0] cur_link;
    int          exp_stall = 0;
    int          exp_flush = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected-queue update at the active edge, using the pre-edge input values.
    always @(posedge clk) begin
        bit out_x;
        bit in_x;
        if (started) begin
            if (!reset_n) begin
                exp_q.delete();
                exp_stall = 0;
                exp_flush = 0;
            end else begin
                out_x = (exp_q.size() > 0) && id_ready;
                in_x  = if_valid && (exp_q.size() < 2) && !if_id_flush;
                if (exp_q.size() > 0 && !id_ready) exp_stall++;
                if (out_x) void'(exp_q.pop_front());
                if (if_id_flush) begin
                    exp_flush += exp_q.size();
                    exp_q.delete();
                end else if (in_x) begin
                    exp_q.push_back('{instr: if_instr, pc: if_pc, link: cur_link,
                                      comp: if_compressed, ill: if_illegal});
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            check("if_ready", 32'(if_ready), 32'(exp_q.size() < 2));
            check("id_valid", 32'(id_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                check("id_instr", id_instr, e.instr);
                check("id_pc", id_pc, e.pc);
                check("id_link_pc", id_link_pc, e.link);
                check("id_compressed", 32'(id_compressed), 32'(e.comp));
                check("id_illegal", 32'(id_illegal), 32'(e.ill));
            end else begin
                check("id_instr_idle", id_instr, 32'h0000_0013);
                check("id_illegal_idle", 32'(id_illegal), 32'd0);
            end
`ifdef IF_ID_PERF_EN
            check("perf_stall_cnt", perf_stall_cnt, 32'(exp_stall));
            check("perf_flush_cnt", perf_flush_cnt, 32'(exp_flush));
`endif
            $display("t=%0t if_ready=%0b id_valid=%0b id_instr=%h id_pc=%h link=%h ill=%0b",
                     $time, if_ready, id_valid, id_instr, id_pc, id_link_pc, id_illegal);
        end
    end

    task automatic drive(bit v, logic [31:0] instr, logic [31:0] pc, logic [31:0] link,
                         bit c, bit il, bit rdy, bit fl);
        @(posedge clk);
        #1;
        if_valid      = v;
        if_instr      = instr;
        if_pc         = pc;
        cur_link      = link;
        if_compressed = c;
        if_illegal    = il;
        id_ready      = rdy;
        if_id_flush   = fl;
    endtask

    task automatic idle(bit rdy);
        drive(1'b0, 32'hDEAD_BEEF, 32'h0000_0FF0, 32'h0000_0FF4, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic check_reset_vals();
        @(negedge clk);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_link_pc", id_link_pc, 32'd4);
        check("rst_id_compressed", 32'(id_compressed), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; cur_link = '0;
        if_compressed = 1'b0; if_illegal = 1'b0; if_id_flush = 1'b0; id_ready = 1'b0;
        @(posedge clk);
        #1 started = 1'b1;
        check_reset_vals();
        reset_n = 1'b1;

        // Streaming at full rate
        drive(1, 32'h0010_0093, 32'h0, 32'h4,  0, 0, 1, 0);
        drive(1, 32'h0020_0113, 32'h4, 32'h8,  0, 0, 1, 0);
        drive(1, 32'h0030_0193, 32'h8, 32'hC,  0, 0, 1, 0);
        drive(1, 32'h0040_0213, 32'hC, 32'h10, 0, 0, 1, 0);
        idle(1);

        // Back-pressure into skid, then drain in order
        drive(1, 32'hAAAA_0001, 32'h10, 32'h14, 0, 0, 0, 0);
        drive(1, 32'hBBBB_0002, 32'h14, 32'h18, 0, 0, 0, 0);
        idle(0);
        idle(1);
        idle(1);
        idle(1);

        // Flush while in SKID with a new instruction offered
        drive(1, 32'hAAAA_0003, 32'h30, 32'h34, 0, 0, 0, 0);
        drive(1, 32'hBBBB_0004, 32'h34, 32'h38, 0, 0, 0, 0);
        drive(1, 32'hCCCC_0005, 32'h38, 32'h3C, 0, 0, 0, 1);
        idle(1);
        idle(1);

        // Link address: compressed step and 32-bit wrap
        drive(1, 32'h0000_0513, 32'h0000_0100, 32'h0000_0102, 1, 0, 1, 0);
        drive(1, 32'h0000_0593, 32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 1, 0);
        drive(1, 32'h0000_0613, 32'hFFFF_FFFE, 32'h0000_0000, 1, 0, 1, 0);
        idle(1);

        // Reset in SKID: held low between edges first, then sampled at the edge
        drive(1, 32'hAAAA_0006, 32'h40, 32'h44, 0, 0, 0, 0);
        drive(1, 32'hBBBB_0007, 32'h44, 32'h48, 0, 0, 0, 0);
        idle(0);
        reset_n = 1'b0;
        @(negedge clk);
        check("sync_reset_hold_valid", 32'(id_valid), 32'd1);
        check_reset_vals();
        reset_n = 1'b1;
        idle(1);

        // Illegal flag follows its entry and clears after drain
        drive(1, 32'h0000_0000, 32'h20, 32'h24, 0, 1, 1, 0);
        idle(1);
        idle(1);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
